// File: rtl/scr1_wb_pkg.sv
// Shared types for the SCR1 Wishbone bridges: core memory-interface enums, bridge FSM
// states, the full-word byte-select constant and the fetch legality helper.
package scr1_wb_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_WBB_IDLE = 2'd0,
    SCR1_WBB_BUS  = 2'd1,
    SCR1_WBB_RESP = 2'd2
  } type_scr1_wbb_fsm_e;

  localparam logic [3:0] SCR1_WB_SEL_WORD = 4'hF;

  // Only word-aligned reads may reach the bus.
  function automatic logic scr1_wbb_fetch_legal(input logic cmd, input logic [1:0] addr_lsb);
    return (cmd == SCR1_MEM_CMD_RD) && (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/scr1_wb_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags expiry.
// TIMEOUT_CYC of 0 disables expiry.
module scr1_wb_timeout #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  generate
    if (TIMEOUT_CYC >= (1 << TO_CNT_W)) begin : g_bad_param
      $error("scr1_wb_timeout: TIMEOUT_CYC does not fit in TO_CNT_W bits");
    end
  endgenerate

  logic [TO_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + TO_CNT_W'(1);
    end
  end

  assign expire_o = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

endmodule

// File: rtl/scr1_imem_wb_bridge.sv
// Instruction-fetch bridge: turns imem request/response handshakes into single
// Wishbone classic read cycles, with local rejection of illegal fetches and a watchdog.
module scr1_imem_wb_bridge #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_ack,
  input  logic              imem_req,
  input  logic              imem_cmd,
  input  logic [AWIDTH-1:0] imem_addr,
  output logic [DWIDTH-1:0] imem_rdata,
  output logic [1:0]        imem_resp,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [AWIDTH-1:0] wbm_adr_o,
  input  logic [DWIDTH-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i
);
  import scr1_wb_pkg::*;

  type_scr1_wbb_fsm_e  state_q, state_d;
  type_scr1_mem_resp_e resp_q, resp_d;
  logic                cyc_q, cyc_d;
  logic [3:0]          sel_q, sel_d;
  logic [AWIDTH-1:0]   adr_q, adr_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                to_clr, to_en, to_expire;

  assign imem_req_ack = imem_req & ((state_q == SCR1_WBB_IDLE) | (state_q == SCR1_WBB_RESP));

  scr1_wb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_CNT_W    (TO_CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expire_o (to_expire)
  );

  always_comb begin
    state_d = state_q;
    resp_d  = SCR1_MEM_RESP_NOTRDY;
    cyc_d   = cyc_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    rdata_d = rdata_q;
    to_clr  = 1'b0;
    to_en   = 1'b0;
    case (state_q)
      SCR1_WBB_IDLE, SCR1_WBB_RESP: begin
        if (imem_req) begin
          if (scr1_wbb_fetch_legal(imem_cmd, imem_addr[1:0])) begin
            state_d = SCR1_WBB_BUS;
            cyc_d   = 1'b1;
            sel_d   = SCR1_WB_SEL_WORD;
            adr_d   = {imem_addr[AWIDTH-1:2], 2'b00};
            to_clr  = 1'b1;
          end else begin
            state_d = SCR1_WBB_RESP;
            resp_d  = SCR1_MEM_RESP_RDY_ER;
            rdata_d = '0;
          end
        end else begin
          state_d = SCR1_WBB_IDLE;
        end
      end
      SCR1_WBB_BUS: begin
        to_en = 1'b1;
        // Error beats ack, ack beats the watchdog.
        if (wbm_err_i) begin
          state_d = SCR1_WBB_RESP;
          resp_d  = SCR1_MEM_RESP_RDY_ER;
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
        end else if (wbm_ack_i) begin
          state_d = SCR1_WBB_RESP;
          resp_d  = SCR1_MEM_RESP_RDY_OK;
          rdata_d = wbm_dat_i;
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
        end else if (to_expire) begin
          state_d = SCR1_WBB_RESP;
          resp_d  = SCR1_MEM_RESP_RDY_ER;
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
        end else begin
          state_d = SCR1_WBB_BUS;
        end
      end
      default: begin
        state_d = SCR1_WBB_IDLE;
        cyc_d   = 1'b0;
        sel_d   = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCR1_WBB_IDLE;
      resp_q  <= SCR1_MEM_RESP_NOTRDY;
      cyc_q   <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      cyc_q   <= cyc_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      rdata_q <= rdata_d;
    end
  end

  assign imem_rdata = rdata_q;
  assign imem_resp  = resp_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = 1'b0;
  assign wbm_sel_o  = sel_q;
  assign wbm_adr_o  = adr_q;

endmodule

// File: tb/tb_scr1_imem_wb_bridge.sv
// Directed bench for scr1_imem_wb_bridge with a short watchdog (TIMEOUT_CYC=4).
module tb_scr1_imem_wb_bridge;

  logic        clk;
  logic        rst;
  logic        req_ack;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  int n_chk;
  int n_err;

  scr1_imem_wb_bridge #(
    .AWIDTH      (32),
    .DWIDTH      (32),
    .TIMEOUT_CYC (4),
    .TO_CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_ack (req_ack),
    .imem_req     (req),
    .imem_cmd     (cmd),
    .imem_addr    (addr),
    .imem_rdata   (rdata),
    .imem_resp    (resp),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_we_o     (we),
    .wbm_sel_o    (sel),
    .wbm_adr_o    (adr),
    .wbm_dat_i    (dat),
    .wbm_ack_i    (ack),
    .wbm_err_i    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single read to a slave that acks in the first bus cycle.
  task automatic zero_wait_read(input string tag, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; cmd = 1'b0; addr = a;
    #1;
    chk({tag, ".ack"}, 32'(req_ack), 32'd1);
    step();
    req = 1'b0; ack = 1'b1; dat = d;
    chk({tag, ".cyc"}, 32'(cyc), 32'd1);
    chk({tag, ".stb"}, 32'(stb), 32'd1);
    chk({tag, ".sel"}, 32'(sel), 32'hF);
    chk({tag, ".we"}, 32'(we), 32'd0);
    chk({tag, ".adr"}, adr, a);
    chk({tag, ".resp_bus"}, 32'(resp), 32'd0);
    step();
    ack = 1'b0;
    chk({tag, ".resp"}, 32'(resp), 32'd1);
    chk({tag, ".rdata"}, rdata, d);
    chk({tag, ".cyc_resp"}, 32'(cyc), 32'd0);
    step();
    chk({tag, ".resp_idle"}, 32'(resp), 32'd0);
    chk({tag, ".rdata_hold"}, rdata, d);
  endtask

  // Request the bridge rejects locally.
  task automatic illegal_req(input string tag, input logic c, input logic [31:0] a);
    req = 1'b1; cmd = c; addr = a;
    #1;
    chk({tag, ".ack"}, 32'(req_ack), 32'd1);
    step();
    req = 1'b0;
    chk({tag, ".resp"}, 32'(resp), 32'd2);
    chk({tag, ".rdata"}, rdata, 32'd0);
    chk({tag, ".cyc"}, 32'(cyc), 32'd0);
    step();
    chk({tag, ".resp_idle"}, 32'(resp), 32'd0);
    chk({tag, ".cyc_idle"}, 32'(cyc), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; req = 1'b0; cmd = 1'b0; addr = 32'd0;
    dat = 32'd0; ack = 1'b0; err = 1'b0;
    step(); step(); step();
    chk("rst.cyc", 32'(cyc), 32'd0);
    chk("rst.stb", 32'(stb), 32'd0);
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.adr", adr, 32'd0);
    chk("rst.resp", 32'(resp), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.req_ack", 32'(req_ack), 32'd0);
    rst = 1'b0;
    step();

    zero_wait_read("zw", 32'h0001_0004, 32'hDEAD_BEEF);

    // Back-to-back fetches, three wait states each, req held high throughout.
    req = 1'b1; cmd = 1'b0; addr = 32'h100;
    #1;
    chk("b2b.ack0", 32'(req_ack), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("b2b%0d.noack_bus", i), 32'(req_ack), 32'd0);
      chk($sformatf("b2b%0d.cyc", i), 32'(cyc), 32'd1);
      chk($sformatf("b2b%0d.adr", i), adr, 32'h100 + 32'(4 * i));
      addr = 32'h100 + 32'(4 * (i + 1));
      for (int w = 0; w < 3; w++) begin
        step();
        chk($sformatf("b2b%0d.cyc_w%0d", i, w), 32'(cyc), 32'd1);
        chk($sformatf("b2b%0d.adr_w%0d", i, w), adr, 32'h100 + 32'(4 * i));
        chk($sformatf("b2b%0d.resp_w%0d", i, w), 32'(resp), 32'd0);
        if (w == 2) begin
          ack = 1'b1;
          dat = 32'hA000_0000 + 32'(i);
        end
      end
      step();
      ack = 1'b0;
      if (i == 2) req = 1'b0;
      #1;
      chk($sformatf("b2b%0d.resp", i), 32'(resp), 32'd1);
      chk($sformatf("b2b%0d.rdata", i), rdata, 32'hA000_0000 + 32'(i));
      chk($sformatf("b2b%0d.cyc_gap", i), 32'(cyc), 32'd0);
      chk($sformatf("b2b%0d.ack_resp", i), 32'(req_ack), (i < 2) ? 32'd1 : 32'd0);
    end
    step();
    chk("b2b.resp_idle", 32'(resp), 32'd0);

    illegal_req("wr", 1'b1, 32'h200);
    illegal_req("misal", 1'b0, 32'h202);

    // Slave error and ack together: error wins, data not captured.
    req = 1'b1; cmd = 1'b0; addr = 32'h300;
    step();
    req = 1'b0; ack = 1'b1; err = 1'b1; dat = 32'h1234_5678;
    chk("errack.cyc", 32'(cyc), 32'd1);
    step();
    ack = 1'b0; err = 1'b0;
    chk("errack.resp", 32'(resp), 32'd2);
    chk("errack.rdata", rdata, 32'd0);
    chk("errack.cyc_drop", 32'(cyc), 32'd0);
    step();
    chk("errack.resp_idle", 32'(resp), 32'd0);

    // Silent slave: cyc stays up for exactly four cycles, then error.
    req = 1'b1; cmd = 1'b0; addr = 32'h400;
    step();
    req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to.cyc%0d", c), 32'(cyc), 32'd1);
      chk($sformatf("to.resp%0d", c), 32'(resp), 32'd0);
      step();
    end
    chk("to.cyc_drop", 32'(cyc), 32'd0);
    chk("to.resp", 32'(resp), 32'd2);
    step();
    chk("to.resp_idle", 32'(resp), 32'd0);
    zero_wait_read("to_after", 32'h404, 32'hCAFE_F00D);

    // Reset during the second wait cycle, then a late ack.
    req = 1'b1; cmd = 1'b0; addr = 32'h500;
    step();
    req = 1'b0;
    chk("mrst.cyc_w1", 32'(cyc), 32'd1);
    step();
    chk("mrst.cyc_w2", 32'(cyc), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; ack = 1'b1; dat = 32'h0000_0055;
    chk("mrst.cyc", 32'(cyc), 32'd0);
    chk("mrst.stb", 32'(stb), 32'd0);
    chk("mrst.sel", 32'(sel), 32'd0);
    chk("mrst.resp", 32'(resp), 32'd0);
    chk("mrst.rdata", rdata, 32'd0);
    step();
    ack = 1'b0;
    chk("mrst.late_resp", 32'(resp), 32'd0);
    chk("mrst.late_cyc", 32'(cyc), 32'd0);
    chk("mrst.late_rdata", rdata, 32'd0);
    step();
    chk("mrst.resp_idle", 32'(resp), 32'd0);
    zero_wait_read("mrst_after", 32'h600, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
